// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Single-outstanding RV32I load/store initiator for dataMemory;
//                lane-aligns stores, extends loads, flags bad accesses.
//  Revision    : 1.0  initial release
// ============================================================================
module load_store_unit #(
   parameter int MEM_LATENCY = 2,
   parameter int ERR_CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_is_store,
   input  logic [2:0]           req_funct3,
   input  logic [31:0]          req_addr,
   input  logic [31:0]          req_wdata,
   output logic                 resp_valid,
   output logic [31:0]          resp_rdata,
   output logic                 resp_error,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic                 mem_read_enable,
   output logic [3:0]           mem_read_byte_select,
   output logic [3:0]           mem_write_byte_select,
   output logic [31:0]          mem_address,
   output logic [31:0]          mem_data_in,
   input  logic [31:0]          mem_data_out
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_STORE = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   localparam logic [1:0]           c_LAST_CNT = 2'(MEM_LATENCY - 1);
   localparam logic [ERR_CNT_W-1:0] c_ERR_MAX  = '1;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [1:0]             r_lat_cnt;
   logic [1:0]             w_lat_cnt_nxt;
   logic [2:0]             r_funct3;
   logic [2:0]             w_funct3_nxt;
   logic [1:0]             r_lane;
   logic [1:0]             w_lane_nxt;

   logic                   r_resp_valid;
   logic                   w_resp_valid;
   logic [31:0]            r_resp_rdata;
   logic [31:0]            w_resp_rdata;
   logic                   r_resp_error;
   logic                   w_resp_error;
   logic [ERR_CNT_W-1:0]   r_err_count;
   logic [ERR_CNT_W-1:0]   w_err_count;
   logic                   r_mem_read_enable;
   logic                   w_mem_read_enable;
   logic [3:0]             r_mem_read_byte_select;
   logic [3:0]             w_mem_read_byte_select;
   logic [3:0]             r_mem_write_byte_select;
   logic [3:0]             w_mem_write_byte_select;
   logic [31:0]            r_mem_address;
   logic [31:0]            w_mem_address;
   logic [31:0]            r_mem_data_in;
   logic [31:0]            w_mem_data_in;

   logic                   w_req_ready;
   logic                   w_req_illegal;
   logic                   w_req_misaligned;
   logic                   w_req_error;
   logic [3:0]             w_store_sel;
   logic [31:0]            w_store_data;
   logic [31:0]            w_shifted;
   logic [31:0]            w_load_data;

   assign w_req_ready = (r_state == S_IDLE);

   // Request decode, evaluated on the raw inputs so the accept edge can
   // register the first-cycle strobes directly.
   always_comb begin
      if (req_is_store) begin
         w_req_illegal = (req_funct3 >= 3'd3);
      end else begin
         w_req_illegal = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) ||
                         (req_funct3 == 3'd7);
      end
      w_req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                         ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
      w_req_error      = w_req_illegal || w_req_misaligned;
   end

   always_comb begin
      case (req_funct3[1:0])
         2'b00: begin
            w_store_sel  = 4'b0001 << req_addr[1:0];
            w_store_data = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            w_store_sel  = 4'b0011 << req_addr[1:0];
            w_store_data = {2{req_wdata[15:0]}};
         end
         default: begin
            w_store_sel  = 4'b1111;
            w_store_data = req_wdata;
         end
      endcase
   end

   assign w_shifted = mem_data_out >> {r_lane, 3'b000};

   always_comb begin
      case (r_funct3)
         3'b000:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
         3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
         3'b010:  w_load_data = mem_data_out;
         3'b100:  w_load_data = {24'd0, w_shifted[7:0]};
         3'b101:  w_load_data = {16'd0, w_shifted[15:0]};
         default: w_load_data = 32'd0;
      endcase
   end

   always_comb begin
      w_state_nxt             = r_state;
      w_lat_cnt_nxt           = r_lat_cnt;
      w_funct3_nxt            = r_funct3;
      w_lane_nxt              = r_lane;
      w_resp_valid            = 1'b0;
      w_resp_rdata            = 32'd0;
      w_resp_error            = 1'b0;
      w_err_count             = r_err_count;
      w_mem_read_enable       = 1'b0;
      w_mem_read_byte_select  = 4'b0000;
      w_mem_write_byte_select = 4'b0000;
      w_mem_address           = 32'd0;
      w_mem_data_in           = 32'd0;

      case (r_state)
         S_IDLE: begin
            if (req_valid && w_req_ready) begin
               w_funct3_nxt = req_funct3;
               w_lane_nxt   = req_addr[1:0];
               if (w_req_error) begin
                  w_state_nxt  = S_RESP;
                  w_resp_valid = 1'b1;
                  w_resp_error = 1'b1;
                  if (r_err_count != c_ERR_MAX) begin
                     w_err_count = r_err_count + 1'b1;
                  end
               end else if (req_is_store) begin
                  w_state_nxt             = S_STORE;
                  w_mem_write_byte_select = w_store_sel;
                  w_mem_data_in           = w_store_data;
                  w_mem_address           = {req_addr[31:2], 2'b00};
               end else begin
                  w_state_nxt            = S_LOAD;
                  w_lat_cnt_nxt          = 2'd0;
                  w_mem_read_enable      = 1'b1;
                  w_mem_read_byte_select = 4'b1111;
                  w_mem_address          = {req_addr[31:2], 2'b00};
               end
            end
         end
         S_LOAD: begin
            if (r_lat_cnt == c_LAST_CNT) begin
               w_state_nxt  = S_RESP;
               w_resp_valid = 1'b1;
               w_resp_rdata = w_load_data;
            end else begin
               w_lat_cnt_nxt          = r_lat_cnt + 2'd1;
               w_mem_read_enable      = 1'b1;
               w_mem_read_byte_select = 4'b1111;
               w_mem_address          = r_mem_address;
            end
         end
         S_STORE: begin
            w_state_nxt  = S_RESP;
            w_resp_valid = 1'b1;
         end
         S_RESP: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state                 <= S_IDLE;
         r_lat_cnt               <= 2'd0;
         r_funct3                <= 3'd0;
         r_lane                  <= 2'd0;
         r_resp_valid            <= 1'b0;
         r_resp_rdata            <= 32'd0;
         r_resp_error            <= 1'b0;
         r_err_count             <= '0;
         r_mem_read_enable       <= 1'b0;
         r_mem_read_byte_select  <= 4'b0000;
         r_mem_write_byte_select <= 4'b0000;
         r_mem_address           <= 32'd0;
         r_mem_data_in           <= 32'd0;
      end else begin
         r_state                 <= w_state_nxt;
         r_lat_cnt               <= w_lat_cnt_nxt;
         r_funct3                <= w_funct3_nxt;
         r_lane                  <= w_lane_nxt;
         r_resp_valid            <= w_resp_valid;
         r_resp_rdata            <= w_resp_rdata;
         r_resp_error            <= w_resp_error;
         r_err_count             <= w_err_count;
         r_mem_read_enable       <= w_mem_read_enable;
         r_mem_read_byte_select  <= w_mem_read_byte_select;
         r_mem_write_byte_select <= w_mem_write_byte_select;
         r_mem_address           <= w_mem_address;
         r_mem_data_in           <= w_mem_data_in;
      end
   end

   assign req_ready             = w_req_ready;
   assign resp_valid            = r_resp_valid;
   assign resp_rdata            = r_resp_rdata;
   assign resp_error            = r_resp_error;
   assign err_count             = r_err_count;
   assign mem_read_enable       = r_mem_read_enable;
   assign mem_read_byte_select  = r_mem_read_byte_select;
   assign mem_write_byte_select = r_mem_write_byte_select;
   assign mem_address           = r_mem_address;
   assign mem_data_in           = r_mem_data_in;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Randomised scoreboard bench for load_store_unit with a
//                byte-array reference model and a small dataMemory stand-in.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_load_store_unit;

   localparam int L     = 2;
   localparam int ERR_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             req_valid;
   logic             req_ready;
   logic             req_is_store;
   logic [2:0]       req_funct3;
   logic [31:0]      req_addr;
   logic [31:0]      req_wdata;
   logic             resp_valid;
   logic [31:0]      resp_rdata;
   logic             resp_error;
   logic [ERR_W-1:0] err_count;
   logic             mem_read_enable;
   logic [3:0]       mem_read_byte_select;
   logic [3:0]       mem_write_byte_select;
   logic [31:0]      mem_address;
   logic [31:0]      mem_data_in;
   logic [31:0]      mem_data_out;

   always #5 clk = ~clk;

   load_store_unit #(.MEM_LATENCY(L), .ERR_CNT_W(ERR_W)) dut (
      .clk                   (clk),
      .rst                   (rst),
      .req_valid             (req_valid),
      .req_ready             (req_ready),
      .req_is_store          (req_is_store),
      .req_funct3            (req_funct3),
      .req_addr              (req_addr),
      .req_wdata             (req_wdata),
      .resp_valid            (resp_valid),
      .resp_rdata            (resp_rdata),
      .resp_error            (resp_error),
      .err_count             (err_count),
      .mem_read_enable       (mem_read_enable),
      .mem_read_byte_select  (mem_read_byte_select),
      .mem_write_byte_select (mem_write_byte_select),
      .mem_address           (mem_address),
      .mem_data_in           (mem_data_in),
      .mem_data_out          (mem_data_out)
   );

   // dataMemory stand-in: 256 bytes, anything above reads as DEADBEEF.
   logic        mem_clear;
   logic [31:0] mem [0:63];
   assign mem_data_out = (mem_address[31:8] == 24'd0) ? mem[mem_address[7:2]] : 32'hDEADBEEF;

   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
      end else if (mem_address[31:8] == 24'd0) begin
         for (int i = 0; i < 4; i++)
            if (mem_write_byte_select[i]) mem[mem_address[7:2]][8*i +: 8] <= mem_data_in[8*i +: 8];
      end
   end

   typedef struct {
      logic [31:0]      rdata;
      logic             err;
      int               resp_cyc;
      int               rcnt;
      int               wcnt;
      logic [3:0]       wsel;
      logic [31:0]      wdata;
      logic [31:0]      addr;
      logic [ERR_W-1:0] errcnt;
   } exp_t;

   exp_t             sb[$];
   int               checks   = 0;
   int               failures = 0;
   int               cyc      = 0;
   logic [7:0]       ref_mem [0:255];
   logic [ERR_W-1:0] err_model = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_word(input logic [31:0] a);
      if (a < 32'd256)
         return {ref_mem[a[7:0] + 8'd3], ref_mem[a[7:0] + 8'd2], ref_mem[a[7:0] + 8'd1], ref_mem[a[7:0]]};
      return 32'hDEADBEEF;
   endfunction

   // Monitor: protocol checks every cycle, scoreboard pop on each response.
   int          mon_rcnt = 0;
   int          mon_wcnt = 0;
   logic [3:0]  mon_wsel = '0;
   logic [31:0] mon_wdata = '0;
   logic [31:0] mon_addr = '0;
   exp_t        mon_e;

   always @(negedge clk) begin
      if (rst) begin
         mon_rcnt = 0;
         mon_wcnt = 0;
      end else begin
         chk("strobe_exclusive", {31'd0, mem_read_enable && (mem_write_byte_select != 4'd0)}, 32'd0);
         chk("read_sel", {28'd0, mem_read_byte_select}, mem_read_enable ? 32'hF : 32'h0);
         chk("addr_low_bits", {30'd0, mem_address[1:0]}, 32'd0);
         if (!mem_read_enable && mem_write_byte_select == 4'd0)
            chk("addr_idle_zero", mem_address, 32'd0);
         if (mem_read_enable) begin
            mon_rcnt++;
            mon_addr = mem_address;
         end
         if (mem_write_byte_select != 4'd0) begin
            mon_wcnt++;
            mon_wsel  = mem_write_byte_select;
            mon_wdata = mem_data_in;
            mon_addr  = mem_address;
         end
         if (resp_valid) begin
            if (sb.size() == 0) begin
               chk("unexpected_resp", {31'd0, resp_valid}, 32'd0);
            end else begin
               mon_e = sb.pop_front();
               chk("resp_rdata", resp_rdata, mon_e.rdata);
               chk("resp_error", {31'd0, resp_error}, {31'd0, mon_e.err});
               chk("resp_cycle", cyc, mon_e.resp_cyc);
               chk("read_cycles", mon_rcnt, mon_e.rcnt);
               chk("write_cycles", mon_wcnt, mon_e.wcnt);
               chk("err_count", {16'd0, err_count}, {16'd0, mon_e.errcnt});
               if (mon_e.wcnt != 0) begin
                  chk("write_sel", {28'd0, mon_wsel}, {28'd0, mon_e.wsel});
                  chk("write_data", mon_wdata, mon_e.wdata);
               end
               if (mon_e.wcnt != 0 || mon_e.rcnt != 0)
                  chk("mem_address", mon_addr, mon_e.addr);
            end
            mon_rcnt = 0;
            mon_wcnt = 0;
         end
      end
   end

   // Called at a negedge; returns at a negedge one cycle after acceptance.
   task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      exp_t        e;
      int          sz;
      int          guard;
      logic        bad;
      logic [31:0] w;
      guard = 0;
      while (!req_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!req_ready) begin
         chk("ready_timeout", {31'd0, req_ready}, 32'd1);
         return;
      end
      sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      bad = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
      if ((int'(a[1:0]) % sz) != 0) bad = 1'b1;
      e = '{rdata: 32'd0, err: 1'b0, resp_cyc: 0, rcnt: 0, wcnt: 0,
            wsel: 4'd0, wdata: 32'd0, addr: a & 32'hFFFFFFFC, errcnt: '0};
      if (bad) begin
         if (err_model != {ERR_W{1'b1}}) err_model = err_model + 1'b1;
         e.err      = 1'b1;
         e.resp_cyc = cyc + 1;
      end else if (st) begin
         e.wcnt     = 1;
         e.resp_cyc = cyc + 2;
         e.wsel     = 4'((1 << sz) - 1) << a[1:0];
         e.wdata    = (sz == 1) ? {4{wd[7:0]}} : (sz == 2) ? {2{wd[15:0]}} : wd;
         for (int b = 0; b < sz; b++)
            if ((a + 32'(b)) < 32'd256) ref_mem[8'(a) + 8'(b)] = wd[8*b +: 8];
      end else begin
         e.rcnt     = L;
         e.resp_cyc = cyc + L + 1;
         w = ref_word(a & 32'hFFFFFFFC) >> (8 * a[1:0]);
         if (sz == 1) begin
            w = w & 32'hFF;
            if (!f3[2] && w[7]) w = w | 32'hFFFFFF00;
         end else if (sz == 2) begin
            w = w & 32'hFFFF;
            if (!f3[2] && w[15]) w = w | 32'hFFFF0000;
         end
         e.rdata = w;
      end
      e.errcnt = err_model;
      sb.push_back(e);
      req_is_store = st;
      req_funct3   = f3;
      req_addr     = a;
      req_wdata    = wd;
      req_valid    = 1'b1;
      @(posedge clk);
      #1;
      req_valid    = 1'b0;
      req_is_store = 1'($urandom);
      req_funct3   = 3'($urandom);
      req_addr     = $urandom;
      req_wdata    = $urandom;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] ra;
      int          guard;
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'd0;
      rst          = 1'b1;
      mem_clear    = 1'b1;
      req_valid    = 1'b0;
      req_is_store = 1'b0;
      req_funct3   = 3'd0;
      req_addr     = 32'd0;
      req_wdata    = 32'd0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_err_count", {16'd0, err_count}, 32'd0);
      chk("rst_read_enable", {31'd0, mem_read_enable}, 32'd0);
      chk("rst_write_sel", {28'd0, mem_write_byte_select}, 32'd0);
      chk("rst_mem_address", mem_address, 32'd0);
      chk("rst_mem_data_in", mem_data_in, 32'd0);
      rst       = 1'b0;
      mem_clear = 1'b0;
      @(negedge clk);

      issue(1'b1, 3'b010, 32'h4, 32'hA5A5A5A5);
      issue(1'b0, 3'b010, 32'h4, 32'h0);
      for (int i = 0; i < 4; i++) issue(1'b1, 3'b000, 32'h8 + 32'(i), 32'hFF);
      issue(1'b0, 3'b010, 32'h8, 32'h0);
      issue(1'b0, 3'b000, 32'h9, 32'h0);
      issue(1'b0, 3'b100, 32'h9, 32'h0);
      issue(1'b1, 3'b001, 32'h12, 32'h8000);
      issue(1'b0, 3'b001, 32'h12, 32'h0);
      issue(1'b0, 3'b101, 32'h12, 32'h0);
      issue(1'b0, 3'b010, 32'h6, 32'h0);
      issue(1'b1, 3'b001, 32'h3, 32'h0);
      issue(1'b0, 3'b011, 32'h0, 32'h0);
      issue(1'b0, 3'b010, 32'hFFFFFFFC, 32'h0);
      issue(1'b0, 3'b000, 32'hFFFFFFFC, 32'h0);

      // Reset during the first LOAD cycle drops the access silently.
      guard = 0;
      while (!req_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      req_is_store = 1'b0;
      req_funct3   = 3'b010;
      req_addr     = 32'h4;
      req_valid    = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      rst       = 1'b1;
      @(negedge clk);
      chk("rst_mid_load_strobe", {31'd0, mem_read_enable}, 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
      chk("post_rst_read_enable", {31'd0, mem_read_enable}, 32'd0);
      chk("post_rst_write_sel", {28'd0, mem_write_byte_select}, 32'd0);
      chk("post_rst_mem_address", mem_address, 32'd0);
      err_model = '0;
      for (int i = 0; i < L + 2; i++) begin
         chk("post_rst_no_resp", {31'd0, resp_valid}, 32'd0);
         @(negedge clk);
      end
      issue(1'b0, 3'b010, 32'h4, 32'h0);

      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(3) == 0) ra = 32'hFFFFFF00 | ($urandom & 32'hFF);
         else                         ra = $urandom_range(63);
         issue(1'($urandom), 3'($urandom), ra, $urandom);
         repeat ($urandom_range(2)) @(negedge clk);
      end

      guard = 0;
      while (sb.size() != 0 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk("scoreboard_drain", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
